// File: rtl/enc_lane_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : enc_lane_scheduler
// Description : Shares the two-lane byte encoder between ordered sets (OS)
//               and transport data (TD), one whole symbol at a time, with
//               TD starvation protection and sticky underrun detection.
// Revision    : 1.0 - initial release
// ============================================================================
module enc_lane_scheduler #(
  parameter int MAX_OS_BURST = 4
) (
  input  logic       enc_clk,
  input  logic       rst,
  input  logic       link_en,
  input  logic [1:0] gen_speed,
  input  logic       os_req,
  input  logic [3:0] os_type,
  input  logic [7:0] os_lane0,
  input  logic [7:0] os_lane1,
  output logic       os_ack,
  input  logic       td_valid,
  input  logic [7:0] td_lane0,
  input  logic [7:0] td_lane1,
  output logic       td_ready,
  output logic [7:0] lane_0_tx,
  output logic [7:0] lane_1_tx,
  output logic [3:0] d_sel,
  output logic       enable,
  output logic       sym_start,
  output logic       underrun
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_OS     = 2'd1;
  localparam logic [1:0] ST_TD     = 2'd2;
  localparam logic [3:0] C_DSEL_TD   = 4'd8;
  localparam logic [3:0] C_DSEL_IDLE = 4'd9;
  localparam logic [2:0] C_BURST_MAX = 3'(MAX_OS_BURST);

  logic [1:0] r_grant;
  logic [3:0] r_cnt;
  logic [1:0] r_spd;
  logic [3:0] r_dsel_q;
  logic [2:0] r_os_burst;
  logic [7:0] r_lane0;
  logic [7:0] r_lane1;
  logic [3:0] r_dsel;
  logic       r_enable;
  logic       r_sym_start;
  logic       r_underrun;

  logic       w_boundary;
  logic       w_off;
  logic [1:0] w_pick;
  logic       w_src_valid;
  logic [2:0] w_burst_inc;

  // Index of the final byte of a symbol for a given speed code
  function automatic logic [3:0] last_idx(input logic [1:0] spd);
    case (spd)
      2'd1:    last_idx = 4'd15;
      2'd2:    last_idx = 4'd7;
      default: last_idx = 4'd0;
    endcase
  endfunction

  // Boundary detection, grant arbitration and byte acceptance handshakes
  always_comb begin
    w_boundary  = (r_cnt == 4'd0) || (r_grant == ST_IDLE);
    w_off       = !link_en || (gen_speed == 2'd3);
    w_pick      = ST_IDLE;
    if (!w_off) begin
      if ((r_os_burst == C_BURST_MAX) && td_valid) w_pick = ST_TD;
      else if (os_req)                             w_pick = ST_OS;
      else if (td_valid)                           w_pick = ST_TD;
    end
    w_src_valid = (r_grant == ST_OS) ? os_req : td_valid;
    w_burst_inc = (r_os_burst == 3'd7) ? r_os_burst : r_os_burst + 3'd1;
    // Handshakes are held low during reset and while the link is disabled
    os_ack      = rst && link_en &&
                  (w_boundary ? (w_pick == ST_OS) : ((r_grant == ST_OS) && os_req));
    td_ready    = rst && link_en &&
                  (w_boundary ? (w_pick == ST_TD) : (r_grant == ST_TD));
  end

  // Grant/counter state and registered encoder-side outputs
  always_ff @(posedge enc_clk or negedge rst) begin
    if (!rst) begin
      r_grant     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_spd       <= 2'd0;
      r_dsel_q    <= C_DSEL_IDLE;
      r_os_burst  <= 3'd0;
      r_lane0     <= 8'h00;
      r_lane1     <= 8'h00;
      r_dsel      <= C_DSEL_IDLE;
      r_enable    <= 1'b0;
      r_sym_start <= 1'b0;
      r_underrun  <= 1'b0;
    end else if (!link_en) begin
      // Flush: abort any symbol in flight without completing it
      r_grant     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_os_burst  <= 3'd0;
      r_lane0     <= 8'h00;
      r_lane1     <= 8'h00;
      r_dsel      <= C_DSEL_IDLE;
      r_enable    <= 1'b0;
      r_sym_start <= 1'b0;
      r_underrun  <= 1'b0;
    end else if (w_boundary) begin
      r_spd   <= gen_speed;
      r_grant <= w_pick;
      case (w_pick)
        ST_OS: begin
          r_dsel_q    <= os_type;
          r_dsel      <= os_type;
          r_lane0     <= os_lane0;
          r_lane1     <= os_lane1;
          r_enable    <= 1'b1;
          r_sym_start <= 1'b1;
          r_cnt       <= (last_idx(gen_speed) == 4'd0) ? 4'd0 : 4'd1;
          r_os_burst  <= td_valid ? w_burst_inc : 3'd0;
        end
        ST_TD: begin
          r_dsel_q    <= C_DSEL_TD;
          r_dsel      <= C_DSEL_TD;
          r_lane0     <= td_lane0;
          r_lane1     <= td_lane1;
          r_enable    <= 1'b1;
          r_sym_start <= 1'b1;
          r_cnt       <= (last_idx(gen_speed) == 4'd0) ? 4'd0 : 4'd1;
          r_os_burst  <= 3'd0;
        end
        default: begin
          r_cnt       <= 4'd0;
          r_lane0     <= 8'h00;
          r_lane1     <= 8'h00;
          r_dsel      <= C_DSEL_IDLE;
          r_enable    <= 1'b0;
          r_sym_start <= 1'b0;
        end
      endcase
    end else begin
      // Mid-symbol: length is fixed by the speed latched at the boundary
      r_cnt       <= (r_cnt == last_idx(r_spd)) ? 4'd0 : r_cnt + 4'd1;
      r_dsel      <= r_dsel_q;
      r_enable    <= 1'b1;
      r_sym_start <= 1'b0;
      if (w_src_valid) begin
        r_lane0 <= (r_grant == ST_OS) ? os_lane0 : td_lane0;
        r_lane1 <= (r_grant == ST_OS) ? os_lane1 : td_lane1;
      end else begin
        r_lane0    <= 8'h00;
        r_lane1    <= 8'h00;
        r_underrun <= 1'b1;
      end
    end
  end

  assign lane_0_tx = r_lane0;
  assign lane_1_tx = r_lane1;
  assign d_sel     = r_dsel;
  assign enable    = r_enable;
  assign sym_start = r_sym_start;
  assign underrun  = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_enc_lane_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_enc_lane_scheduler
// Description : Self-checking bench for enc_lane_scheduler using a symbol-
//               level reference model (bytes-remaining counting).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_enc_lane_scheduler;

  localparam int MAX_B = 4;

  logic       enc_clk = 1'b0;
  logic       rst;
  logic       link_en;
  logic [1:0] gen_speed;
  logic       os_req;
  logic [3:0] os_type;
  logic [7:0] os_lane0, os_lane1;
  logic       os_ack;
  logic       td_valid;
  logic [7:0] td_lane0, td_lane1;
  logic       td_ready;
  logic [7:0] lane_0_tx, lane_1_tx;
  logic [3:0] d_sel;
  logic       enable, sym_start, underrun;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_src;    // 0 none, 1 OS, 2 TD
  int m_left;   // bytes still to send in current symbol after this one
  int m_type;
  int m_burst;
  bit m_under;
  // Expected values
  bit       e_ack, e_rdy, e_en, e_sym, e_und;
  bit [7:0] e_l0, e_l1;
  bit [3:0] e_dsel;

  enc_lane_scheduler #(.MAX_OS_BURST(MAX_B)) dut (
    .enc_clk(enc_clk), .rst(rst), .link_en(link_en), .gen_speed(gen_speed),
    .os_req(os_req), .os_type(os_type), .os_lane0(os_lane0), .os_lane1(os_lane1),
    .os_ack(os_ack), .td_valid(td_valid), .td_lane0(td_lane0), .td_lane1(td_lane1),
    .td_ready(td_ready), .lane_0_tx(lane_0_tx), .lane_1_tx(lane_1_tx),
    .d_sel(d_sel), .enable(enable), .sym_start(sym_start), .underrun(underrun)
  );

  always #5 enc_clk = ~enc_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_outs();
    e_l0 = 8'h00; e_l1 = 8'h00; e_dsel = 4'd9; e_en = 1'b0; e_sym = 1'b0;
  endtask

  task automatic model_reset();
    m_src = 0; m_left = 0; m_type = 9; m_burst = 0; m_under = 1'b0;
    e_ack = 1'b0; e_rdy = 1'b0; e_und = 1'b0;
    idle_outs();
  endtask

  // One clock of the reference model, using inputs as currently driven
  task automatic model_cycle();
    int pick, len;
    bit v;
    e_ack = 1'b0; e_rdy = 1'b0;
    if (!rst) begin
      model_reset();
    end else if (!link_en) begin
      m_src = 0; m_left = 0; m_burst = 0; m_under = 1'b0;
      idle_outs();
    end else if (m_left == 0) begin
      pick = 0;
      if (gen_speed != 2'd3) begin
        if (m_burst == MAX_B && td_valid) pick = 2;
        else if (os_req)                  pick = 1;
        else if (td_valid)                pick = 2;
      end
      m_src = pick;
      if (pick == 0) begin
        idle_outs();
      end else begin
        len    = (gen_speed == 2'd0) ? 1 : ((gen_speed == 2'd1) ? 16 : 8);
        m_left = len - 1;
        e_en   = 1'b1;
        e_sym  = 1'b1;
        if (pick == 1) begin
          m_type  = os_type;
          m_burst = td_valid ? ((m_burst < 7) ? m_burst + 1 : 7) : 0;
          e_ack   = 1'b1;
          e_l0    = os_lane0; e_l1 = os_lane1;
        end else begin
          m_type  = 8;
          m_burst = 0;
          e_rdy   = 1'b1;
          e_l0    = td_lane0; e_l1 = td_lane1;
        end
        e_dsel = m_type[3:0];
      end
    end else begin
      v      = (m_src == 1) ? os_req : td_valid;
      e_ack  = (m_src == 1) && os_req;
      e_rdy  = (m_src == 2);
      e_en   = 1'b1;
      e_sym  = 1'b0;
      e_dsel = m_type[3:0];
      if (v) begin
        e_l0 = (m_src == 1) ? os_lane0 : td_lane0;
        e_l1 = (m_src == 1) ? os_lane1 : td_lane1;
      end else begin
        e_l0 = 8'h00; e_l1 = 8'h00;
        m_under = 1'b1;
      end
      m_left--;
    end
    e_und = m_under;
  endtask

  task automatic check_outs(input string pfx);
    check({pfx, ".lane0"},     lane_0_tx, e_l0);
    check({pfx, ".lane1"},     lane_1_tx, e_l1);
    check({pfx, ".d_sel"},     d_sel,     e_dsel);
    check({pfx, ".enable"},    enable,    e_en);
    check({pfx, ".sym_start"}, sym_start, e_sym);
    check({pfx, ".underrun"},  underrun,  e_und);
  endtask

  task automatic set_in(input bit le, input logic [1:0] g, input bit oq,
                        input logic [3:0] ot, input bit tv);
    link_en = le; gen_speed = g; os_req = oq; os_type = ot; td_valid = tv;
    os_lane0 = 8'($urandom); os_lane1 = 8'($urandom);
    td_lane0 = 8'($urandom); td_lane1 = 8'($urandom);
  endtask

  // Called at posedge+1; checks handshakes mid-cycle and outputs after the edge
  task automatic step(input string pfx);
    #2;
    model_cycle();
    check({pfx, ".os_ack"},   os_ack,   e_ack);
    check({pfx, ".td_ready"}, td_ready, e_rdy);
    @(posedge enc_clk);
    #1;
    check_outs(pfx);
  endtask

  initial begin
    rst = 1'b0;
    set_in(1'b1, 2'd1, 1'b1, 4'd2, 1'b1);
    model_reset();
    #7;
    check("reset.os_ack", os_ack, 1'b0);
    check("reset.td_ready", td_ready, 1'b0);
    check_outs("reset");
    @(posedge enc_clk); #1;
    rst = 1'b1;
    set_in(1'b0, 2'd1, 1'b0, 4'd0, 1'b0);
    step("flush");

    // Gen3 TD stream, bytes 0x00..0x1F
    for (int i = 0; i < 32; i++) begin
      set_in(1'b1, 2'd1, 1'b0, 4'd0, 1'b1);
      td_lane0 = 8'(i); td_lane1 = 8'(8'hFF - i);
      step("gen3_td");
    end
    set_in(1'b0, 2'd1, 1'b0, 4'd0, 1'b0);
    step("gap1");

    // Gen2 OS preempting TD: 4 OS symbols then forced TD, then OS again
    for (int i = 0; i < 8 * 7; i++) begin
      set_in(1'b1, 2'd2, 1'b1, 4'd3, 1'b1);
      step("gen2_burst");
    end
    set_in(1'b0, 2'd2, 1'b0, 4'd0, 1'b0);
    step("gap2");

    // Underrun: TD drops at bytes 5..7 of a Gen3 symbol
    for (int i = 0; i < 34; i++) begin
      set_in(1'b1, 2'd1, 1'b0, 4'd0, !(i >= 5 && i <= 7));
      step("underrun");
    end

    // Speed change 1->2 at byte 9 of a Gen3 symbol
    set_in(1'b0, 2'd1, 1'b0, 4'd0, 1'b0);
    step("gap3");
    for (int i = 0; i < 30; i++) begin
      set_in(1'b1, (i >= 9) ? 2'd2 : 2'd1, 1'b0, 4'd0, 1'b1);
      step("speed_chg");
    end

    // Abort at byte 3 of a Gen2 OS symbol, then re-enable
    set_in(1'b0, 2'd2, 1'b0, 4'd0, 1'b0);
    step("gap4");
    for (int i = 0; i < 16; i++) begin
      set_in((i != 3) && (i != 4), 2'd2, 1'b1, 4'd5, 1'b0);
      step("abort");
    end

    // Gen4 alternating sources
    for (int i = 0; i < 12; i++) begin
      set_in(1'b1, 2'd0, i[0] == 1'b0, 4'(i % 8), i[0] == 1'b1);
      step("gen4_alt");
    end

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      set_in($urandom_range(0, 19) != 0, 2'($urandom_range(0, 3)),
             $urandom_range(0, 2) != 0, 4'($urandom_range(0, 7)),
             $urandom_range(0, 2) != 0);
      step("random");
    end

    // Async reset mid-stream of a Gen3 TD symbol
    for (int i = 0; i < 6; i++) begin
      set_in(1'b1, 2'd1, 1'b0, 4'd0, 1'b1);
      step("pre_rst");
    end
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("arst.os_ack", os_ack, 1'b0);
    check("arst.td_ready", td_ready, 1'b0);
    check_outs("arst");
    @(posedge enc_clk); #1;
    check_outs("arst_hold");
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_in(1'b1, 2'd1, 1'b0, 4'd0, 1'b1);
      step("post_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/enc_lane_scheduler.md
# enc_lane_scheduler

Scheduler that sits in front of the two-lane 8b-byte encoder. It shares the encoder between two byte sources: ordered sets from the LTSSM (OS) and transport-layer data (TD). It grants the encoder one whole symbol at a time (16 bytes Gen3, 8 bytes Gen2, 1 byte Gen4) and drives the encoder's `lane_0_tx`/`lane_1_tx`, `d_sel` and `enable` inputs. It also provides starvation protection for TD and underrun detection.

## Interface
- `MAX_OS_BURST`, default 4: consecutive OS symbols allowed while TD is pending before TD is forced.
- `enc_clk`  in  1  encoder clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `link_en`  in  1  scheduler enable; low = flush to IDLE.
- `gen_speed`  in  2  0 = Gen4 (N=1), 1 = Gen3 (N=16), 2 = Gen2 (N=8), 3 = reserved (treated as disabled).
- `os_req`  in  1  OS byte pair available.
- `os_type`  in  4  ordered-set code 0–7; sampled at grant.
- `os_lane0`, `os_lane1`  in  8 each  OS bytes.
- `os_ack`  out  1  OS byte pair consumed this cycle.
- `td_valid`  in  1  TD byte pair available.
- `td_lane0`, `td_lane1`  in  8 each  TD bytes.
- `td_ready`  out  1  TD byte pair consumed this cycle when `td_valid`.
- `lane_0_tx`, `lane_1_tx`  out  8 each  bytes to encoder.
- `d_sel`  out  4  8 = transport, 0–7 = OS type, 9 = idle.
- `enable`  out  1  encoder enable.
- `sym_start`  out  1  pulses with first byte of each symbol.
- `underrun`  out  1  sticky: granted source went invalid mid-symbol.

## Operation
- **State:** grant ∈ {IDLE, OS, TD}; byte counter `cnt` (4 bit); latched speed `spd`; latched `d_sel_q`; `os_burst` counter (3 bit, saturating).
- **Symbol length:** N = 16/8/1 from `spd`. `cnt` runs 0..N-1, then wraps to 0.
- **Boundary cycle:** `cnt`==0 or grant==IDLE. The decision is made combinationally in this cycle.
  - If `link_en`=0 or `gen_speed`=3: next grant = IDLE.
  - Else if `os_burst`==MAX_OS_BURST and `td_valid`: grant TD.
  - Else if `os_req`: grant OS.
  - Else if `td_valid`: grant TD.
  - Else: IDLE.
  - `gen_speed` is latched into `spd` only here. A speed change mid-symbol takes effect at the next boundary.
  - `os_type` is latched into `d_sel_q` on an OS grant; 8 is latched on a TD grant.
- **Byte acceptance:**
  - The first byte of a symbol is accepted in the boundary cycle (`os_ack`/`td_ready`=1).
  - Subsequent bytes: `os_ack` = grant==OS && `os_req`; `td_ready` = grant==TD.
  - `os_ack` and `td_ready` never assert together.
- **Underrun:** while mid-symbol (`cnt`≠0) with the granted source invalid, drive 0x00 on both lanes, still advance `cnt`, and set `underrun`. The symbol length never shrinks.
- **os_burst:**
  - +1 per OS grant made while `td_valid`=1 (saturating).
  - Cleared on TD grant, or on any OS grant made with `td_valid`=0.
- **Going idle:**
  - `link_en` low mid-symbol: abort immediately. Next cycle grant=IDLE, `cnt`=0, `enable`=0, `d_sel`=9, lanes 0x00, `underrun` cleared, `os_burst` cleared.
  - `link_en` low also holds `underrun` clear.
- **Gen4 (N=1):** every cycle is a boundary; `sym_start`=1 on every granted cycle.

## Timing
- All outputs registered. Accepted byte pair appears on `lane_x_tx` one cycle after its ack/ready cycle, together with `d_sel`=`d_sel_q`, `enable`=1, and `sym_start` (first byte only).
- `os_ack`/`td_ready` are combinational from state, `cnt`, `link_en`, `os_burst`, `os_req` and `td_valid` (boundary cycle only). Sources must present the next byte every cycle while granted.
- Reset values:
  - `lane_0_tx`=`lane_1_tx`=0x00, `d_sel`=9, `enable`=0, `sym_start`=0, `underrun`=0.
  - `os_ack`=0, `td_ready`=0.
  - grant=IDLE, `cnt`=0, `spd`=0, `os_burst`=0.
- A symbol occupies exactly N consecutive output cycles. Back-to-back symbols have no gap when a request is present at the boundary.
- Simultaneous `os_req`+`td_valid` at a boundary: OS wins unless the burst limit is reached.
- Reset asserted mid-symbol: all state is cleared asynchronously, with no partial symbol completion.

## Test plan
- **Gen3 TD stream:** `gen_speed`=1, `td_valid` held, bytes 0x00..0x1F.
  - Expect two symbols of 16 cycles each, `d_sel`=8, `sym_start` at output cycles 1 and 17, `enable`=1 from cycle 1.
- **Gen2 OS preempting TD:** `gen_speed`=2, `td_valid` and `os_req` (`os_type`=3) both high.
  - Expect 4 OS symbols (`d_sel`=3, 8 bytes each), then one TD symbol (`d_sel`=8), then OS resumes.
- **Underrun:** Gen3 TD, drop `td_valid` at byte 5 for 3 cycles.
  - Expect bytes 5–7 output as 0x00, `underrun`=1 sticky, symbol still 16 cycles, next `sym_start` on time.
- **Speed change mid-symbol:** change `gen_speed` 1→2 at byte 9 of a Gen3 symbol.
  - Expect current symbol completes 16 bytes; next symbol is 8 bytes.
- **Abort:** `link_en` low at byte 3 of a Gen2 symbol.
  - Expect next cycle `enable`=0, `d_sel`=9, lanes 0x00, `underrun` cleared.
  - Re-enable with `os_req`: expect `sym_start` one cycle after the ack.
- **Gen4 and async reset:** Gen4 passthrough with alternating `os_req`/`td_valid` yields a per-cycle `d_sel` switch.
  - Async `rst` low mid-stream: expect all outputs at reset values within the same cycle.
